raster_engine: RTL
==================

// Module: raster_engine
// PURPOSE
//  Parametrised successor to the 8x8 monochrome rasterizer. Accepts draw commands over a valid/ready port and rasterises
//  them into an internal WxH frame buffer, BPP bits/pixel, at one pixel per cycle.
//  Supported commands are CLEAR, PLOT, clipped RECT fill and Bresenham LINE. Streams the frame row-major over a
//  valid/ready pixel port. Sits between the command decoder and the display/serialiser.
// PARAMETERS
//  XB          3  x coordinate bits; W = 2**XB columns
//  YB          3  y coordinate bits; H = 2**YB rows
//  BPP         4  bits per pixel (colour index)
//  AUTO_FLUSH  1  1: every CLEAR/PLOT/RECT/LINE is followed by a frame stream; 0: stream only on FLUSH
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous, active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       engine accepts command (high only in IDLE)
//  cmd_op     in   3       0 NOP, 1 CLEAR, 2 PLOT, 3 RECT, 4 LINE, 5 FLUSH, 6-7 NOP
//  cmd_x1/y1  in   XB/YB   start point / rect origin
//  cmd_x2/y2  in   XB/YB   LINE end point
//  cmd_w/h    in   XB/YB   RECT extent in pixels (0 = empty)
//  cmd_color  in   BPP     colour written by CLEAR/PLOT/RECT/LINE
//  pix_valid  out  1       pix_data valid
//  pix_ready  in   1       sink accepts pixel
//  pix_data   out  BPP     pixel at (pix_x,pix_y)
//  pix_first  out  1       with pix_valid: pixel (0,0) (frame sync)
//  pix_last   out  1       with pix_valid: pixel (W-1,H-1)
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1, pix_valid=0, pix_first=0, pix_last=0, busy=0, pix_data=0.
//  Frame buffer contents are NOT reset (RAM-inferable); software issues CLEAR after reset.
//  Command is accepted on cmd_valid&&cmd_ready. All fields are latched that cycle; cmd_ready drops next cycle.
//  States: IDLE, FILL, LINE, STREAM.
//  - NOP: stays IDLE, no effect.
//  - PLOT: write in the accept cycle + 1. Then STREAM if AUTO_FLUSH, else IDLE.
//  - CLEAR: FILL over the full frame, W*H cycles, 1 write/cycle, row-major.
//  - RECT: FILL over x in [x1, min(x1+w,W)-1], y in [y1, min(y1+h,H)-1]. Sums are computed at XB+1/YB+1 bits;
//    anything past the edge is clipped, never wrapped. Cycles = clipped area.
//  - RECT with w==0 or h==0: zero writes. Goes to STREAM (if AUTO_FLUSH) or IDLE the next cycle.
//  - LINE: integer Bresenham from (x1,y1) to (x2,y2), all octants, one pixel/cycle, both endpoints inclusive.
//    Cycles = max(|dx|,|dy|)+1. A degenerate line (x1==x2, y1==y2) writes exactly one pixel.
//  - FLUSH: goes to STREAM directly with no write.
//  - After the last write: STREAM if AUTO_FLUSH, else IDLE.
//  STREAM: address starts at 0 and advances on pix_valid&&pix_ready.
//   pix_valid is held high and pix_data stable while stalled.
//   Exactly W*H beats. The beat with pix_last && pix_ready returns to IDLE; cmd_ready=1 next cycle.
//   Within a stream, pixel values reflect buffer state at stream start (no writes occur during STREAM).
//  Writes and reads never overlap: single-port buffer, one access/cycle.
//  Async reset mid-command or mid-stream: immediate return to IDLE. Partial draws remain in the buffer.
//  The stream is aborted with no pix_last.
// STRUCTURE
//  raster_pkg: op encodings (OP_NOP..OP_FLUSH), state enum, default XB/YB/BPP.
//  Sub-module raster_line_stepper: Bresenham error/step unit.
//   Ports: start(x1,y1,x2,y2) -> x, y, step, done. Signed error is XB+2 bits wide.
//  Top level holds the FSM, FILL row/col counters, stream counter and frame buffer array.
// TESTING
//  1 Reset, then CLEAR color=5 with AUTO_FLUSH=1 -> 64 fill cycles, then 64 beats all 5.
//    pix_first on beat 0, pix_last on beat 63 only.
//  2 PLOT (7,7) color=F after a CLEAR of 0 -> stream beat 63 = F, all others 0.
//    Unlike the old design, (7,7) is a plain plot, not a clear.
//  3 RECT x1=6,y1=5,w=4,h=7 -> clipped to x 6..7, y 5..7: 6 fill cycles, exactly 6 pixels set.
//    RECT w=0 -> no pixel changes.
//  4 LINE (0,7)->(7,3) and (2,2)->(2,2) -> pixels match a Bresenham model, 8 and 1 write cycles.
//    Swapping the endpoints gives an identical pixel set.
//  5 Random pix_ready stalls during STREAM -> no duplicated or dropped beat, pix_data stable while stalled.
//    cmd_ready stays low until the final handshake.
//  6 rst_n asserted mid-RECT and mid-STREAM -> cmd_ready=1, pix_valid=0 asynchronously.
//    A subsequent FLUSH (AUTO_FLUSH=0) streams the partial image.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared encodings and default geometry for the raster engine and its line stepper.
package raster_pkg;

  localparam int XB_DEF  = 3;
  localparam int YB_DEF  = 3;
  localparam int BPP_DEF = 4;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_CLEAR = 3'd1,
    OP_PLOT  = 3'd2,
    OP_RECT  = 3'd3,
    OP_LINE  = 3'd4,
    OP_FLUSH = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_LINE,
    ST_STREAM
  } state_e;

endpackage

// File: rtl/raster_line_stepper.sv
// Bresenham stepper: loads both endpoints on start, then presents one pixel per step
// until the end point is reached (done stays high on the end pixel).
module raster_line_stepper
  import raster_pkg::*;
#(
  parameter int XB = XB_DEF,
  parameter int YB = YB_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XB-1:0] x1,
  input  logic [YB-1:0] y1,
  input  logic [XB-1:0] x2,
  input  logic [YB-1:0] y2,
  input  logic          step,
  output logic [XB-1:0] x,
  output logic [YB-1:0] y,
  output logic          done
);

  localparam int CB = (XB > YB) ? XB : YB;
  localparam int EW = CB + 2;

  logic [XB-1:0]        x_q, x_d, xe_q, xe_d;
  logic [YB-1:0]        y_q, y_d, ye_q, ye_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                 sx_q, sx_d, sy_q, sy_d;

  logic signed [EW-1:0] x_diff, y_diff, dx0, dy0;
  logic signed [EW:0]   e2, dx_w, dy_w;
  logic                 step_x, step_y;

  // dy is kept as -|dy| so a single error term covers all octants.
  always_comb begin
    x_diff = $signed(EW'(x2)) - $signed(EW'(x1));
    y_diff = $signed(EW'(y2)) - $signed(EW'(y1));
    dx0    = (x_diff < 0) ? -x_diff : x_diff;
    dy0    = (y_diff < 0) ? y_diff : -y_diff;
    e2     = $signed({err_q, 1'b0});
    dx_w   = $signed({dx_q[EW-1], dx_q});
    dy_w   = $signed({dy_q[EW-1], dy_q});
    step_x = (e2 >= dy_w);
    step_y = (e2 <= dx_w);
  end

  assign done = (x_q == xe_q) && (y_q == ye_q);
  assign x    = x_q;
  assign y    = y_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    xe_d  = xe_q;
    ye_d  = ye_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    err_d = err_q;
    if (start) begin
      x_d   = x1;
      y_d   = y1;
      xe_d  = x2;
      ye_d  = y2;
      dx_d  = dx0;
      dy_d  = dy0;
      sx_d  = (x_diff < 0);
      sy_d  = (y_diff < 0);
      err_d = dx0 + dy0;
    end else if (step && !done) begin
      if (step_x) begin
        x_d   = sx_q ? x_q - XB'(1) : x_q + XB'(1);
        err_d = err_d + dy_q;
      end
      if (step_y) begin
        y_d   = sy_q ? y_q - YB'(1) : y_q + YB'(1);
        err_d = err_d + dx_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      xe_q  <= '0;
      ye_q  <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
      err_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      xe_q  <= xe_d;
      ye_q  <= ye_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/raster_engine.sv
// Command-driven rasteriser: CLEAR/PLOT/RECT fill and Bresenham LINE into a WxH frame
// buffer, streamed out row-major over a valid/ready pixel port.
module raster_engine
  import raster_pkg::*;
#(
  parameter int XB         = XB_DEF,
  parameter int YB         = YB_DEF,
  parameter int BPP        = BPP_DEF,
  parameter bit AUTO_FLUSH = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic [XB-1:0]  cmd_x1,
  input  logic [YB-1:0]  cmd_y1,
  input  logic [XB-1:0]  cmd_x2,
  input  logic [YB-1:0]  cmd_y2,
  input  logic [XB-1:0]  cmd_w,
  input  logic [YB-1:0]  cmd_h,
  input  logic [BPP-1:0] cmd_color,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic [BPP-1:0] pix_data,
  output logic           pix_first,
  output logic           pix_last,
  output logic           busy
);

  localparam int AB   = XB + YB;
  localparam int NPIX = 1 << AB;

  state_e         state_q, state_d, after_draw;
  op_e            op;
  logic           accept, rect_empty, fill_last, stream_last;
  logic           line_start, line_step, line_done, mem_we;
  logic [XB-1:0]  line_x, rect_x_hi;
  logic [YB-1:0]  line_y, rect_y_hi;
  logic [XB:0]    x_end;
  logic [YB:0]    y_end;
  logic [AB-1:0]  waddr;

  logic [XB-1:0]  fx_q, fx_d, fx_lo_q, fx_lo_d, fx_hi_q, fx_hi_d;
  logic [YB-1:0]  fy_q, fy_d, fy_hi_q, fy_hi_d;
  logic [BPP-1:0] color_q, color_d;
  logic [AB-1:0]  saddr_q, saddr_d;
  logic [BPP-1:0] mem [NPIX];

  assign op          = op_e'(cmd_op);
  assign accept      = cmd_valid && cmd_ready;
  assign line_start  = accept && (op == OP_LINE);
  assign after_draw  = AUTO_FLUSH ? ST_STREAM : ST_IDLE;
  assign rect_empty  = (cmd_w == '0) || (cmd_h == '0);
  assign fill_last   = (fx_q == fx_hi_q) && (fy_q == fy_hi_q);
  assign stream_last = (saddr_q == '1);

  // Extents are summed one bit wider; a set carry means the rect reaches the edge and clips there.
  assign x_end     = {1'b0, cmd_x1} + {1'b0, cmd_w};
  assign y_end     = {1'b0, cmd_y1} + {1'b0, cmd_h};
  assign rect_x_hi = x_end[XB] ? '1 : x_end[XB-1:0] - XB'(1);
  assign rect_y_hi = y_end[YB] ? '1 : y_end[YB-1:0] - YB'(1);

  raster_line_stepper #(.XB(XB), .YB(YB)) u_line (
    .clk   (clk),
    .rst_n (rst_n),
    .start (line_start),
    .x1    (cmd_x1),
    .y1    (cmd_y1),
    .x2    (cmd_x2),
    .y2    (cmd_y2),
    .step  (line_step),
    .x     (line_x),
    .y     (line_y),
    .done  (line_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_CLEAR, OP_PLOT: state_d = ST_FILL;
            OP_RECT:           state_d = rect_empty ? after_draw : ST_FILL;
            OP_LINE:           state_d = ST_LINE;
            OP_FLUSH:          state_d = ST_STREAM;
            default:           state_d = ST_IDLE;
          endcase
        end
      end
      ST_FILL:   if (fill_last) state_d = after_draw;
      ST_LINE:   if (line_done) state_d = after_draw;
      ST_STREAM: if (pix_ready && stream_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    pix_valid = 1'b0;
    mem_we    = 1'b0;
    line_step = 1'b0;
    waddr     = {fy_q, fx_q};
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_FILL: mem_we = 1'b1;
      ST_LINE: begin
        mem_we    = 1'b1;
        waddr     = {line_y, line_x};
        line_step = !line_done;
      end
      ST_STREAM: pix_valid = 1'b1;
      default: ;
    endcase
  end

  assign pix_first = pix_valid && (saddr_q == '0);
  assign pix_last  = pix_valid && stream_last;
  assign pix_data  = pix_valid ? mem[saddr_q] : '0;

  // PLOT is a 1x1 fill and CLEAR a full-frame fill, so one walker serves all three.
  always_comb begin
    fx_d    = fx_q;
    fy_d    = fy_q;
    fx_lo_d = fx_lo_q;
    fx_hi_d = fx_hi_q;
    fy_hi_d = fy_hi_q;
    color_d = color_q;
    saddr_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          color_d = cmd_color;
          fx_d    = cmd_x1;
          fy_d    = cmd_y1;
          fx_lo_d = cmd_x1;
          fx_hi_d = cmd_x1;
          fy_hi_d = cmd_y1;
          if (op == OP_CLEAR) begin
            fx_d    = '0;
            fy_d    = '0;
            fx_lo_d = '0;
            fx_hi_d = '1;
            fy_hi_d = '1;
          end else if (op == OP_RECT) begin
            fx_hi_d = rect_x_hi;
            fy_hi_d = rect_y_hi;
          end
        end
      end
      ST_FILL: begin
        if (fx_q == fx_hi_q) begin
          fx_d = fx_lo_q;
          fy_d = fy_q + YB'(1);
        end else begin
          fx_d = fx_q + XB'(1);
        end
      end
      ST_STREAM: saddr_d = pix_ready ? saddr_q + AB'(1) : saddr_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fx_q    <= '0;
      fy_q    <= '0;
      fx_lo_q <= '0;
      fx_hi_q <= '0;
      fy_hi_q <= '0;
      color_q <= '0;
      saddr_q <= '0;
    end else begin
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fx_lo_q <= fx_lo_d;
      fx_hi_q <= fx_hi_d;
      fy_hi_q <= fy_hi_d;
      color_q <= color_d;
      saddr_q <= saddr_d;
    end
  end

  // NOTE: the frame buffer is deliberately not reset so it can map onto RAM; software clears it after power-up.
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= color_q;
  end

endmodule
